de2_115_sd_card_nios_cpu_oci_dct_unpacker: RTL and testbench

//  Consumer side of the OCI data-compression-trace (DCT) path. The trace packer fills a 30-bit
//  dct_buffer with up to 15 two-bit trace symbols and a 4-bit dct_count; this block accepts those

---
 rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg.sv | 20 ++
 rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker_if.sv | 24 ++
 rtl/de2_115_sd_card_nios_cpu_oci_dct_stats.sv | 42 ++++
 rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker.sv | 96 +++++++++
 tb/tb_de2_115_sd_card_nios_cpu_oci_dct_unpacker.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg.sv
// Shared constants, state encoding and helpers for the OCI DCT frame unpacker.
package de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned NSYM    = 15;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned FRAME_W = SYM_W * NSYM;
    localparam int unsigned STAT_W  = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Saturating increment for the optional statistics counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker_if.sv
// Frame-in / symbol-out bus of the DCT unpacker; slave = unpacker, master = frame source + sink.
interface de2_115_sd_card_nios_cpu_oci_dct_unpacker_if;
    import de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg::*;

    logic [FRAME_W-1:0] dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               frame_valid;
    logic               frame_ready;
    logic               flush;
    logic [SYM_W-1:0]   sym_data;
    logic               sym_valid;
    logic               sym_last;
    logic               sym_ready;

    modport slave (
        input  dct_buffer, dct_count, frame_valid, flush, sym_ready,
        output frame_ready, sym_data, sym_valid, sym_last
    );

    modport master (
        output dct_buffer, dct_count, frame_valid, flush, sym_ready,
        input  frame_ready, sym_data, sym_valid, sym_last
    );
endinterface

// File: rtl/de2_115_sd_card_nios_cpu_oci_dct_stats.sv
// Saturating counters of accepted non-empty frames and transferred symbols; flush clears them.
module de2_115_sd_card_nios_cpu_oci_dct_stats
    import de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              frame_inc_i,
    input  logic              sym_inc_i,
    output logic [STAT_W-1:0] stat_frames_o,
    output logic [STAT_W-1:0] stat_symbols_o
);
    logic [STAT_W-1:0] frames_q, frames_d;
    logic [STAT_W-1:0] symbols_q, symbols_d;

    // Next counter values; clear has priority over increments.
    always_comb begin
        frames_d  = frames_q;
        symbols_d = symbols_q;
        if (clear_i) begin
            frames_d  = '0;
            symbols_d = '0;
        end else begin
            if (frame_inc_i) frames_d  = sat_inc(frames_q);
            if (sym_inc_i)   symbols_d = sat_inc(symbols_q);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frames_q  <= '0;
            symbols_q <= '0;
        end else begin
            frames_q  <= frames_d;
            symbols_q <= symbols_d;
        end
    end

    assign stat_frames_o  = frames_q;
    assign stat_symbols_o = symbols_q;
endmodule

// File: rtl/de2_115_sd_card_nios_cpu_oci_dct_unpacker.sv
// OCI DCT unpacker: accepts packed 30-bit trace frames and replays them one 2-bit symbol per cycle.
// Optional statistics outputs are built when DE2_115_OCI_DCT_STATS_EN is defined.
module de2_115_sd_card_nios_cpu_oci_dct_unpacker
    import de2_115_sd_card_nios_cpu_oci_dct_unpacker_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    de2_115_sd_card_nios_cpu_oci_dct_unpacker_if.slave bus
`ifdef DE2_115_OCI_DCT_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_frames,
    output logic [STAT_W-1:0] stat_symbols
`endif
);
    state_e             state_q, state_d;
    logic [FRAME_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               valid_q, valid_d;
    logic               rdy_en_q;

    logic xfer_c;
    logic last_c;
    logic frame_ready_c;
    logic accept_c;
    logic load_c;

    assign xfer_c        = valid_q & bus.sym_ready;
    assign last_c        = (rem_q == CNT_W'(1));
    // Ready when empty, or when the final symbol leaves this cycle so the next frame follows gaplessly.
    assign frame_ready_c = rdy_en_q & ~bus.flush & ((state_q == IDLE) | (xfer_c & last_c));
    assign accept_c      = bus.frame_valid & frame_ready_c;
    assign load_c        = accept_c & (bus.dct_count != CNT_W'(0));

    // Next-state and datapath: flush aborts, a transfer shifts, a non-empty accepted frame reloads.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        if (bus.flush) begin
            state_d = IDLE;
            shreg_d = '0;
            rem_d   = '0;
            valid_d = 1'b0;
        end else begin
            if (xfer_c) begin
                shreg_d = shreg_q >> SYM_W;
                rem_d   = rem_q - CNT_W'(1);
                if (last_c) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                end
            end
            if (load_c) begin
                state_d = SHIFT;
                shreg_d = bus.dct_buffer;
                rem_d   = bus.dct_count;
                valid_d = 1'b1;
            end
        end
    end

    // State and datapath registers; rdy_en_q holds frame_ready low until the first edge after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            rem_q    <= '0;
            valid_q  <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            rem_q    <= rem_d;
            valid_q  <= valid_d;
            rdy_en_q <= 1'b1;
        end
    end

    assign bus.frame_ready = frame_ready_c;
    assign bus.sym_data    = shreg_q[SYM_W-1:0];
    assign bus.sym_valid   = valid_q;
    assign bus.sym_last    = last_c;

`ifdef DE2_115_OCI_DCT_STATS_EN
    de2_115_sd_card_nios_cpu_oci_dct_stats u_stats (
        .clk            (clk),
        .reset_n        (reset_n),
        .clear_i        (bus.flush),
        .frame_inc_i    (load_c),
        .sym_inc_i      (xfer_c),
        .stat_frames_o  (stat_frames),
        .stat_symbols_o (stat_symbols)
    );
`endif
endmodule

// File: tb/tb_de2_115_sd_card_nios_cpu_oci_dct_unpacker.sv
// Self-checking bench for the OCI DCT unpacker: vector table, corner sequences, randomized run
// against a queue-based model of the symbol stream.
module tb_de2_115_sd_card_nios_cpu_oci_dct_unpacker;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    de2_115_sd_card_nios_cpu_oci_dct_unpacker_if bus ();

`ifdef DE2_115_OCI_DCT_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_symbols;
    logic [15:0] m_sf;
    logic [15:0] m_ss;
`endif

    de2_115_sd_card_nios_cpu_oci_dct_unpacker dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
`ifdef DE2_115_OCI_DCT_STATS_EN
        ,
        .stat_frames  (stat_frames),
        .stat_symbols (stat_symbols)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: symbols still to be emitted for the frame in flight.
    logic [1:0] q[$];
    bit         m_rdy;

    // Observed outputs of the last cycle, for the sequence-level checks.
    logic       obs_valid, obs_last, obs_fr;
    logic [1:0] obs_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, then advance the model.
    task automatic cycle(input logic rn, input logic fv, input logic [29:0] b,
                         input logic [3:0] c, input logic sr, input logic fl);
        logic e_fr, e_valid, e_last, xfer, acc;
        @(negedge clk);
        reset_n         = rn;
        bus.frame_valid = fv;
        bus.dct_buffer  = b;
        bus.dct_count   = c;
        bus.sym_ready   = sr;
        bus.flush       = fl;
        if (!rn) begin
            q.delete();
            m_rdy = 0;
`ifdef DE2_115_OCI_DCT_STATS_EN
            m_sf = '0;
            m_ss = '0;
`endif
        end
        #1;
        e_valid = (q.size() != 0);
        e_last  = (q.size() == 1);
        e_fr    = m_rdy && !fl && (q.size() == 0 || (sr && q.size() == 1));
        chk("frame_ready", 32'(bus.frame_ready), 32'(e_fr));
        chk("sym_valid", 32'(bus.sym_valid), 32'(e_valid));
        chk("sym_last", 32'(bus.sym_last), 32'(e_last));
        if (!rn)          chk("sym_data_rst", 32'(bus.sym_data), 32'd0);
        else if (e_valid) chk("sym_data", 32'(bus.sym_data), 32'(q[0]));
`ifdef DE2_115_OCI_DCT_STATS_EN
        chk("stat_frames", 32'(stat_frames), 32'(m_sf));
        chk("stat_symbols", 32'(stat_symbols), 32'(m_ss));
`endif
        obs_valid = bus.sym_valid;
        obs_last  = bus.sym_last;
        obs_data  = bus.sym_data;
        obs_fr    = bus.frame_ready;
        if (rn) begin
            xfer  = e_valid && sr;
            acc   = fv && e_fr;
            m_rdy = 1;
            if (fl) begin
                q.delete();
`ifdef DE2_115_OCI_DCT_STATS_EN
                m_sf = '0;
                m_ss = '0;
`endif
            end else begin
                if (xfer) begin
                    void'(q.pop_front());
`ifdef DE2_115_OCI_DCT_STATS_EN
                    if (m_ss != 16'hFFFF) m_ss = m_ss + 16'd1;
`endif
                end
                if (acc && c != 0) begin
                    for (int k = 0; k < int'(c); k++) q.push_back(b[2*k +: 2]);
`ifdef DE2_115_OCI_DCT_STATS_EN
                    if (m_sf != 16'hFFFF) m_sf = m_sf + 16'd1;
`endif
                end
            end
        end
    endtask

    typedef struct {
        logic [29:0] bufv;
        logic [3:0]  cnt;
        int          exp_n;
        logic [1:0]  exp_first;
        logic [1:0]  exp_last;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, lastidx, nvalid, nlast, nxfer, seen_after;
        logic [1:0] first_d, last_d;
        logic [29:0] rb;
        logic [3:0]  rc;

        checks  = 0;
        errors  = 0;
        m_rdy   = 0;
        reset_n = 1'b0;
        bus.frame_valid = 1'b0;
        bus.dct_buffer  = '0;
        bus.dct_count   = '0;
        bus.sym_ready   = 1'b0;
        bus.flush       = 1'b0;
`ifdef DE2_115_OCI_DCT_STATS_EN
        m_sf = '0;
        m_ss = '0;
`endif

        tbl[0] = '{30'h3FFF_FFE4, 4'd3,  3,  2'd0, 2'd2};
        tbl[1] = '{30'h0000_0000, 4'd0,  0,  2'd0, 2'd0};
        tbl[2] = '{30'h0000_0003, 4'd1,  1,  2'd3, 2'd3};
        tbl[3] = '{30'h2000_0000, 4'd15, 15, 2'd0, 2'd2};
        tbl[4] = '{30'h0000_001B, 4'd3,  3,  2'd3, 2'd1};
        tbl[5] = '{30'h3FFF_FFFF, 4'd2,  2,  2'd3, 2'd3};

        // Reset held for three cycles, then released.
        for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 0, 0);
        cycle(1, 0, '0, '0, 0, 0);
        cycle(1, 0, '0, '0, 0, 0);
        chk("ready_after_reset", 32'(obs_fr), 32'd1);

        // Vector table: one frame each, drained with sym_ready high.
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, tbl[i].bufv, tbl[i].cnt, 1, 0);
            n = 0; lastidx = -1; first_d = '0; last_d = '0;
            for (int j = 0; j < 20; j++) begin
                cycle(1, 0, '0, '0, 1, 0);
                if (obs_valid) begin
                    if (n == 0) first_d = obs_data;
                    last_d = obs_data;
                    if (obs_last) lastidx = n;
                    n++;
                end
            end
            chk($sformatf("vec%0d_count", i), 32'(n), 32'(tbl[i].exp_n));
            chk($sformatf("vec%0d_lastidx", i), 32'(lastidx), 32'(tbl[i].exp_n - 1));
            if (tbl[i].exp_n > 0) begin
                chk($sformatf("vec%0d_first", i), 32'(first_d), 32'(tbl[i].exp_first));
                chk($sformatf("vec%0d_last", i), 32'(last_d), 32'(tbl[i].exp_last));
            end
        end

        // Back-to-back 15-symbol frames: 30 symbols without a bubble.
        cycle(1, 1, 30'(32'h1234_5678), 4'd15, 1, 0);
        nvalid = 0; nlast = 0; lastidx = 0;
        for (int j = 1; j <= 30; j++) begin
            cycle(1, (j <= 15), 30'(32'h2A5A_C3F0), 4'd15, 1, 0);
            if (obs_valid) nvalid++;
            if (obs_last) begin
                nlast++;
                lastidx = lastidx + j;
            end
        end
        chk("b2b_valid_cycles", 32'(nvalid), 32'd30);
        chk("b2b_last_count", 32'(nlast), 32'd2);
        chk("b2b_last_pos_sum", 32'(lastidx), 32'd45);
        for (int j = 0; j < 3; j++) cycle(1, 0, '0, '0, 1, 0);

        // Stalled drain: sym_ready alternates on a 4-symbol frame.
        cycle(1, 1, 30'h0000_00E4, 4'd4, 0, 0);
        nxfer = 0;
        for (int j = 0; j < 12; j++) begin
            cycle(1, 0, '0, '0, j[0] == 1'b0, 0);
            if (obs_valid && (j[0] == 1'b0)) nxfer++;
        end
        chk("stall_transfers", 32'(nxfer), 32'd4);

        // Flush after the second of five symbols; the frame offered alongside must be refused.
        cycle(1, 1, 30'h0000_03E4, 4'd5, 1, 0);
        cycle(1, 0, '0, '0, 1, 0);
        cycle(1, 0, '0, '0, 1, 0);
        cycle(1, 1, 30'h0000_0155, 4'd5, 0, 1);
        chk("flush_refuses_frame", 32'(obs_fr), 32'd0);
        seen_after = 0;
        for (int j = 0; j < 6; j++) begin
            cycle(1, 0, '0, '0, 1, 0);
            if (obs_valid) seen_after++;
        end
        chk("flush_no_symbols", 32'(seen_after), 32'd0);

        // Reset pulse mid-frame behaves like a flush.
        cycle(1, 1, 30'h0000_03E4, 4'd5, 1, 0);
        cycle(1, 0, '0, '0, 1, 0);
        cycle(1, 0, '0, '0, 1, 0);
        cycle(0, 0, '0, '0, 1, 0);
        seen_after = 0;
        for (int j = 0; j < 6; j++) begin
            cycle(1, 0, '0, '0, 1, 0);
            if (obs_valid) seen_after++;
        end
        chk("reset_no_symbols", 32'(seen_after), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rb = 30'($urandom);
            rc = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            cycle(($urandom_range(0, 299) != 0), 1'($urandom_range(0, 1)), rb, rc,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
